// File: rtl/fifo_word_packer.sv
// -----------------------------------------------------------------------------
// fifo_word_packer
//
// Read-side consumer for a circular byte FIFO. Bytes are drained through the
// FIFO read port (registered read data, one cycle latency) and packed
// little-endian into 32-bit words. Words leave on a valid/ready stream with a
// per-byte keep mask. A partial word is emitted on an explicit flush request
// or after TIMEOUT idle cycles. Everything runs in the FIFO read clock domain.
//
// Parameters
//   TIMEOUT     idle cycles with a partial word before an automatic flush;
//               0 disables the timeout.
//
// Ports
//   r_clk       in   read-domain clock
//   reset_n     in   asynchronous active-low reset
//   en          in   allow new FIFO reads (reads in flight still complete)
//   flush       in   single-cycle request to emit the current partial word
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO read data, valid the cycle after an accepted read
//   fifo_r_en   out  FIFO read enable (combinational)
//   out_data    out  packed word, byte i in bits [8i+7:8i]
//   out_keep    out  per-byte valid mask for out_data
//   out_valid   out  out_data / out_keep valid
//   out_ready   in   downstream accepts the word
//   word_count  out  words emitted, wraps modulo 2^16
// -----------------------------------------------------------------------------
module fifo_word_packer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        r_clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        flush,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_r_en,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] word_count
);

    // Idle counter must be able to represent TIMEOUT-1 before it wraps.
    localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT == 0) ? '0 : IW'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0][7:0] pack_q, pack_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            rd_pend_q;
    logic            flush_req_q, flush_req_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [31:0]     out_data_q, out_data_d;
    logic [3:0]      out_keep_q, out_keep_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     word_count_q, word_count_d;

    // ------------------------------------------------------------------
    // Control terms
    // ------------------------------------------------------------------
    logic       room;
    logic       capture;
    logic       slot_free;
    logic       xfer;
    logic       tmo_hit;
    logic [3:0] cnt_plus_pend;

    // Bytes held plus the one in flight must leave a free slot in pack,
    // so a capture never lands on a full register.
    assign cnt_plus_pend = {1'b0, cnt_q} + {3'b000, rd_pend_q};
    assign room          = (cnt_plus_pend < 4'd4);

    assign fifo_r_en = reset_n & en & ~fifo_empty & ~flush_req_q & room;

    assign capture   = rd_pend_q;
    assign slot_free = ~out_valid_q | out_ready;

    // A flushed partial word waits for any in-flight byte so it is included.
    // cnt==4 implies rd_pend==0, so transfer and capture never coincide.
    assign xfer = slot_free &
                  ((cnt_q == 3'd4) |
                   (flush_req_q & (cnt_q != 3'd0) & ~rd_pend_q));

    // ------------------------------------------------------------------
    // Outgoing word: unfilled bytes forced to zero
    // ------------------------------------------------------------------
    logic [3:0][7:0] word_masked;
    logic [3:0]      keep_mask;

    always_comb begin
        word_masked = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < cnt_q) word_masked[i] = pack_q[i];
        end
    end

    always_comb begin
        keep_mask = 4'b0000;
        case (cnt_q)
            3'd1:    keep_mask = 4'b0001;
            3'd2:    keep_mask = 4'b0011;
            3'd3:    keep_mask = 4'b0111;
            3'd4:    keep_mask = 4'b1111;
            default: keep_mask = 4'b0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Pack register and fill count
    // ------------------------------------------------------------------
    always_comb begin
        pack_d = pack_q;
        cnt_d  = cnt_q;
        if (xfer) begin
            cnt_d = 3'd0;
        end else if (capture) begin
            pack_d[cnt_q[1:0]] = fifo_data;
            cnt_d              = cnt_q + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Idle timeout
    // ------------------------------------------------------------------
    always_comb begin
        idle_d  = idle_q;
        tmo_hit = 1'b0;
        if (TIMEOUT == 0) begin
            idle_d = '0;
        end else if (xfer || capture || (cnt_q == 3'd0)) begin
            idle_d = '0;
        end else if (!flush_req_q) begin
            // Only counts while nothing else is going to emit the word.
            if (idle_q == IDLE_LAST) begin
                idle_d  = '0;
                tmo_hit = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Flush request
    // ------------------------------------------------------------------
    always_comb begin
        flush_req_d = flush_req_q;
        if (xfer) begin
            flush_req_d = 1'b0;
        end else if (flush_req_q && (cnt_q == 3'd0) && !rd_pend_q) begin
            // Nothing to emit: drop the request silently.
            flush_req_d = 1'b0;
        end
        // A new request in the same cycle as a transfer survives it and
        // applies to the next partial word.
        if (tmo_hit || flush) flush_req_d = 1'b1;
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_comb begin
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_valid_d  = out_valid_q;
        word_count_d = word_count_q;
        if (xfer) begin
            out_data_d   = word_masked;
            out_keep_d   = keep_mask;
            out_valid_d  = 1'b1;
            word_count_d = word_count_q + 16'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge r_clk or negedge reset_n) begin
        if (!reset_n) begin
            pack_q       <= '0;
            cnt_q        <= 3'd0;
            rd_pend_q    <= 1'b0;
            flush_req_q  <= 1'b0;
            idle_q       <= '0;
            out_data_q   <= 32'h0;
            out_keep_q   <= 4'h0;
            out_valid_q  <= 1'b0;
            word_count_q <= 16'h0;
        end else begin
            pack_q       <= pack_d;
            cnt_q        <= cnt_d;
            rd_pend_q    <= fifo_r_en;
            flush_req_q  <= flush_req_d;
            idle_q       <= idle_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_valid_q  <= out_valid_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_keep   = out_keep_q;
    assign out_valid  = out_valid_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_word_packer
//
// Directed scenarios followed by a randomized run. The FIFO is a byte queue
// with one-cycle registered read data; emitted words are collected from the
// output handshake and compared against expected words or, in the random
// phase, against the byte stream pushed into the FIFO.
// -----------------------------------------------------------------------------
module tb_fifo_word_packer;

    localparam int TMO = 16;

    logic        r_clk      = 1'b0;
    logic        reset_n    = 1'b0;
    logic        en         = 1'b0;
    logic        flush      = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data  = 8'h00;
    logic        out_ready  = 1'b0;
    logic        fifo_r_en;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic [15:0] word_count;

    fifo_word_packer #(.TIMEOUT(TMO)) dut (
        .r_clk      (r_clk),
        .reset_n    (reset_n),
        .en         (en),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        int          c;
    } wrd_t;

    wrd_t        got[$];     // accepted words with the cycle they were taken
    logic [7:0]  fq[$];      // FIFO contents
    int          rd_cyc[$];  // cycle of every read issued
    int          ntests = 0;
    int          nfail  = 0;
    int          cyc    = 0;
    bit          hold_v = 1'b0;
    logic [31:0] hold_d;
    logic [3:0]  hold_k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // One clock cycle: sample at the falling edge, update FIFO model after
    // the rising edge.
    task automatic tick();
        logic rd;
        @(negedge r_clk);
        rd = fifo_r_en;
        if (fifo_empty) chk("r_en_while_empty", 32'(fifo_r_en), 32'd0);
        if (rd) rd_cyc.push_back(cyc);
        if (hold_v) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, hold_d);
            chk("hold_keep", 32'(out_keep), 32'(hold_k));
        end
        hold_v = reset_n && out_valid && !out_ready;
        hold_d = out_data;
        hold_k = out_keep;
        if (out_valid && out_ready) got.push_back('{out_data, out_keep, cyc});
        @(posedge r_clk);
        #1;
        cyc++;
        if (rd && fq.size() > 0) fifo_data = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic wait_words(input int n, input int budget);
        int b;
        b = budget;
        while (got.size() < n && b > 0) begin
            tick();
            b--;
        end
        chk("wait_words", 32'(got.size() >= n), 32'd1);
    endtask

    task automatic chk_word(input string tag, input int idx, input logic [31:0] d, input logic [3:0] k);
        if (idx < got.size()) begin
            chk({tag, "_data"}, got[idx].d, d);
            chk({tag, "_keep"}, 32'(got[idx].k), 32'(k));
        end
    endtask

    initial begin
        int g0, base, b;
        logic [7:0] exp_bytes[$];
        logic [7:0] out_bytes[$];
        logic [7:0] rb;

        // ---------------- reset ----------------
        en = 1'b1;
        push(8'hEE);
        #1;
        chk("rst_r_en", 32'(fifo_r_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_keep", 32'(out_keep), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        fq.delete();
        fifo_empty = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // ---------------- full word, latency ----------------
        out_ready = 1'b1;
        g0 = got.size();
        base = rd_cyc.size();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_words(g0 + 1, 40);
        chk_word("A", g0, 32'h44332211, 4'hF);
        chk("A_valid_1cyc", 32'(out_valid), 32'd0);
        chk("A_wc", 32'(word_count), 32'd1);
        chk("A_reads", 32'(rd_cyc.size() - base), 32'd4);
        if (got.size() > g0 && rd_cyc.size() > base)
            chk("A_latency", 32'(got[g0].c), 32'(rd_cyc[base] + 6));

        // ---------------- explicit flush ----------------
        g0 = got.size();
        push(8'hA1); push(8'hA2);
        repeat (6) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_words(g0 + 1, 20);
        chk_word("B", g0, 32'h0000A2A1, 4'h3);
        chk("B_wc", 32'(word_count), 32'd2);

        // flush with nothing held
        g0 = got.size();
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (25) tick();
        chk("B_empty_flush_words", 32'(got.size()), 32'(g0));
        chk("B_empty_flush_wc", 32'(word_count), 32'd2);

        // ---------------- idle timeout ----------------
        g0 = got.size();
        base = rd_cyc.size();
        push(8'h5C);
        wait_words(g0 + 1, 40);
        chk_word("C", g0, 32'h0000005C, 4'h1);
        // read at r, capture at end of r+1, 16 idle cycles, transfer cycle,
        // word visible in r+19
        if (got.size() > g0 && rd_cyc.size() > base)
            chk("C_latency", 32'(got[g0].c), 32'(rd_cyc[base] + 19));
        chk("C_wc", 32'(word_count), 32'd3);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        g0 = got.size();
        base = rd_cyc.size();
        for (int i = 0; i < 12; i++) push(8'(i));
        repeat (20) tick();
        chk("D_valid", 32'(out_valid), 32'd1);
        chk("D_data", out_data, 32'h03020100);
        chk("D_keep", 32'(out_keep), 32'hF);
        chk("D_reads", 32'(rd_cyc.size() - base), 32'd8);
        chk("D_wc_hold", 32'(word_count), 32'd4);
        out_ready = 1'b1;
        wait_words(g0 + 3, 60);
        chk_word("D0", g0, 32'h03020100, 4'hF);
        chk_word("D1", g0 + 1, 32'h07060504, 4'hF);
        chk_word("D2", g0 + 2, 32'h0B0A0908, 4'hF);
        chk("D_wc", 32'(word_count), 32'd6);

        // ---------------- en low mid-stream ----------------
        g0 = got.size();
        base = rd_cyc.size();
        for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
        b = 20;
        while (rd_cyc.size() - base < 2 && b > 0) begin
            tick();
            b--;
        end
        en = 1'b0;
        repeat (6) tick();
        chk("E_reads_stopped", 32'(rd_cyc.size() - base), 32'd2);
        en = 1'b1;
        wait_words(g0 + 2, 60);
        chk_word("E0", g0, 32'h63626160, 4'hF);
        chk_word("E1", g0 + 1, 32'h67666564, 4'hF);
        chk("E_wc", 32'(word_count), 32'd8);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        base = rd_cyc.size();
        for (int i = 0; i < 7; i++) push(8'h80 + 8'(i));
        b = 40;
        while (rd_cyc.size() - base < 7 && b > 0) begin
            tick();
            b--;
        end
        repeat (3) tick();
        chk("F_pre_valid", 32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        hold_v  = 1'b0;
        #1;
        chk("F_rst_valid", 32'(out_valid), 32'd0);
        chk("F_rst_data", out_data, 32'd0);
        chk("F_rst_keep", 32'(out_keep), 32'd0);
        chk("F_rst_wc", 32'(word_count), 32'd0);
        chk("F_rst_r_en", 32'(fifo_r_en), 32'd0);
        tick();
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        g0 = got.size();
        push(8'h90); push(8'h91); push(8'h92); push(8'h93);
        wait_words(g0 + 1, 40);
        chk_word("F", g0, 32'h93929190, 4'hF);
        chk("F_wc", 32'(word_count), 32'd1);

        // ---------------- randomized run ----------------
        g0 = got.size();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0 && exp_bytes.size() < 300) begin
                rb = 8'($urandom);
                exp_bytes.push_back(rb);
                push(rb);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            tick();
        end
        flush     = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        repeat (300) tick();
        chk("G_fifo_drained", 32'(fq.size()), 32'd0);
        for (int w = g0; w < got.size(); w++) begin
            chk("G_keep_shape", 32'(got[w].k inside {4'h1, 4'h3, 4'h7, 4'hF}), 32'd1);
            for (int j = 0; j < 4; j++) begin
                if (got[w].k[j]) out_bytes.push_back(got[w].d[j*8 +: 8]);
                else chk("G_pad_zero", 32'(got[w].d[j*8 +: 8]), 32'd0);
            end
        end
        chk("G_byte_count", 32'(out_bytes.size()), 32'(exp_bytes.size()));
        for (int j = 0; j < exp_bytes.size() && j < out_bytes.size(); j++)
            chk("G_byte", 32'(out_bytes[j]), 32'(exp_bytes[j]));
        chk("G_wc", 32'(word_count), 32'(16'(1 + got.size() - g0)));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-side consumer for the circular byte FIFO. It drains 8-bit entries through the FIFO read port and packs them little-endian into 32-bit words. Each word goes out on a valid/ready stream with a byte-keep mask. Partial words are emitted on an explicit flush or after an idle timeout. It runs entirely in the FIFO read clock domain.

## Interface
Parameters:
- TIMEOUT, default 16: idle cycles with a partial word before an automatic flush; 0 disables the timeout.

Ports:
- r_clk  in  1  read-domain clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  when low, no new FIFO reads are issued; reads already in flight still complete.
- flush  in  1  single-cycle request to emit the current partial word.
- fifo_empty  in  1  FIFO EMPTY flag.
- fifo_data  in  8  FIFO registered read data; valid in the cycle after an accepted read.
- fifo_r_en  out  1  FIFO read enable.
- out_data  out  32  packed word; byte i sits in bits [8i+7:8i].
- out_keep  out  4  per-byte valid mask for out_data.
- out_valid  out  1  out_data and out_keep are valid.
- out_ready  in  1  downstream accepts the word.
- word_count  out  16  number of words emitted; wraps modulo 2^16.

## Operation
- State:
  - pack register, 4 x 8 bits;
  - cnt, 0..4, bytes held in pack;
  - rd_pend, a read was issued last cycle;
  - flush_req flag;
  - idle counter;
  - output register (out_data, out_keep, out_valid).
- Read issue: fifo_r_en = reset_n & en & ~fifo_empty & ~flush_req & (cnt + rd_pend < 4).
  - Combinational.
  - Never asserted while fifo_empty is high.
- rd_pend <= fifo_r_en each edge.
- Capture: when rd_pend=1, pack[cnt] <= fifo_data and cnt increments. The issue guard guarantees cnt<4 at capture.
- The output slot is free when out_valid=0 or out_ready=1.
- Transfer fires at the edge when the slot is free and either:
  - cnt==4, or
  - flush_req=1 and cnt>0 and rd_pend=0.
- On transfer:
  - out_data <= pack, with unfilled bytes forced to 0x00;
  - out_keep <= (1<<cnt)-1;
  - out_valid <= 1;
  - cnt <= 0;
  - flush_req <= 0;
  - word_count increments.
- Handshake:
  - out_valid=1 with out_ready=1 at an edge completes the word.
  - Without a new transfer that edge, out_valid <= 0.
  - While out_valid=1 and out_ready=0, out_data and out_keep hold stable.
- Flush:
  - flush=1 sets flush_req.
  - flush_req stops new reads, waits for rd_pend to drain, then transfers the partial word.
  - If cnt==0 and rd_pend==0 while flush_req=1, flush_req clears at the next edge and no word is emitted.
  - flush while flush_req is already set has no additional effect.
- Timeout (TIMEOUT>0):
  - The idle counter increments in cycles with cnt>0, rd_pend=0 and flush_req=0.
  - It clears on any capture, on transfer, or when cnt==0.
  - When it reaches TIMEOUT, flush_req is set and the counter clears.
- A full word (cnt==4) always transfers as soon as the output slot frees; flush_req is irrelevant to it.

## Timing
- Reset (async assert, sync-released state):
  - out_valid=0, out_data=0, out_keep=0, word_count=0;
  - cnt=0, rd_pend=0, flush_req=0, idle counter 0;
  - fifo_r_en=0 while reset_n is low.
- Reset asserted mid-operation discards pack contents and any pending output word immediately; no partial emit.
- Read latency: fifo_r_en high in cycle t means fifo_data is captured at the end of cycle t+1.
- Full-word latency:
  - reads issued in cycles t..t+3;
  - cnt==4 in cycle t+5;
  - out_valid=1 from cycle t+6, given a free slot.
- Sustained throughput: 4 bytes per 6 cycles with out_ready held high. Reads stall in the two cycles where cnt+rd_pend==4.
- Backpressure: with out_valid=1 and out_ready=0, a second word can fill pack (cnt==4); reads then stop until the slot frees.
- Simultaneous events:
  - transfer and capture cannot share an edge for the same byte slot;
  - flush in the cycle of a full-word transfer sets flush_req, which then applies to the following partial word;
  - out_ready and a new transfer on the same edge produce back-to-back out_valid with no bubble.

## Test plan
- FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1 -> one word out_data=0x44332211, out_keep=0xF, out_valid for 1 cycle, word_count=1, fifo_r_en never high while fifo_empty=1.
- Bytes 0xA1,0xA2 then FIFO empty, flush pulse -> out_data=0x0000A2A1, out_keep=0x3; flush with cnt==0 -> no word, word_count unchanged.
- TIMEOUT=16, single byte 0x5C then FIFO empty -> partial word 0x0000005C, out_keep=0x1, emitted exactly 16 idle cycles after capture, plus transfer cycle.
- 12 bytes 0x00..0x0B with out_ready held low for 20 cycles -> out_data holds 0x03020100 stable, reads stop after 8 bytes consumed; release out_ready -> words 0x07060504, 0x0B0A0908 follow, word_count=3.
- en=0 mid-stream after 2 reads issued -> both bytes captured, no further fifo_r_en; en=1 resumes with correct byte ordering.
- reset_n pulsed low while cnt==3 and out_valid=1 -> all outputs 0 immediately, next 4 bytes form a fresh word with out_keep=0xF.
